// File: rtl/ocr_score_accumulator_if.sv
// Handshake bundle between a score producer, the frame accumulator and the classifier.
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface ocr_score_accumulator_if #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 10
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_ovf;
    logic [COUNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_count
    );
endinterface

// File: rtl/ocr_score_accumulator.sv
// Accumulates FRAME_LEN unsigned match scores into one frame score with a sticky carry flag.
// Optional feature: define SCORE_SATURATE_EN to clamp the sum at all-ones on carry-out.
module ocr_score_accumulator #(
    parameter int WIDTH     = 32,
    parameter int COUNT_W   = 10,
    parameter int FRAME_LEN = 784
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    ocr_score_accumulator_if.slave   bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [COUNT_W-1:0] LAST_BEAT = COUNT_W'(FRAME_LEN - 1);

    state_e             state;
    logic [WIDTH-1:0]   acc;
    logic [COUNT_W-1:0] count;
    logic               ovf;
    logic               out_valid_q;
    logic               in_ready_q;

    logic [WIDTH:0]     sum_full;
    logic               carry;
    logic [WIDTH-1:0]   acc_next;
    logic               beat;

    always_comb begin
        // NOTE: every always_comb target gets a value on every path, so no latch is inferred.
        sum_full = {1'b0, acc} + {1'b0, bus.in_data};
        carry    = sum_full[WIDTH];
`ifdef SCORE_SATURATE_EN
        // Once clamped, the sum stays pinned for the rest of the frame.
        acc_next = (carry || ovf) ? '1 : sum_full[WIDTH-1:0];
`else
        acc_next = sum_full[WIDTH-1:0];
`endif
    end

    assign beat = bus.in_valid && in_ready_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (clr) begin
            state       <= ACCUM;
            acc         <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        acc   <= acc_next;
                        ovf   <= ovf | carry;
                        count <= count + COUNT_W'(1);
                        // The final beat is folded in before the result is presented.
                        if (count == LAST_BEAT) begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        acc         <= '0;
                        count       <= '0;
                        ovf         <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ACCUM;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign bus.out_count = count;
endmodule
